// File: rtl/icmp_share_arbiter.sv
// Round-robin arbiter in front of one shared LLVM-icmp comparator.
// One registered result slot, tagged with the index of the winning requester.
module icmp_share_arbiter #(
  parameter int ParamBitWidth = 32,
  parameter int ParamNumReq   = 4,
  parameter int ParamIdWidth  = (ParamNumReq > 1) ? $clog2(ParamNumReq) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [ParamNumReq-1:0]             req_valid,
  output logic [ParamNumReq-1:0]             req_ready,
  input  logic [4*ParamNumReq-1:0]           req_op,
  input  logic [ParamBitWidth*ParamNumReq-1:0] req_lhs,
  input  logic [ParamBitWidth*ParamNumReq-1:0] req_rhs,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [ParamIdWidth-1:0]            rsp_id,
  output logic                               rsp_ret,
  output logic                               rsp_err
);

  typedef enum logic [3:0] {
    OP_EQ  = 4'd0, OP_NE  = 4'd1, OP_UGT = 4'd2, OP_UGE = 4'd3, OP_ULT = 4'd4,
    OP_ULE = 4'd5, OP_SGT = 4'd6, OP_SGE = 4'd7, OP_SLT = 4'd8, OP_SLE = 4'd9
  } icmp_op_e;

  // Returns {err, ret}; undefined predicate codes report err with ret forced low.
  function automatic logic [1:0] icmp_eval(input logic [3:0] op,
                                           input logic [ParamBitWidth-1:0] a,
                                           input logic [ParamBitWidth-1:0] b);
    logic eq, u_lt, s_lt;
    eq   = (a == b);
    u_lt = (a < b);
    s_lt = ($signed(a) < $signed(b));
    case (op)
      OP_EQ:   icmp_eval = {1'b0, eq};
      OP_NE:   icmp_eval = {1'b0, !eq};
      OP_UGT:  icmp_eval = {1'b0, !u_lt && !eq};
      OP_UGE:  icmp_eval = {1'b0, !u_lt};
      OP_ULT:  icmp_eval = {1'b0, u_lt};
      OP_ULE:  icmp_eval = {1'b0, u_lt || eq};
      OP_SGT:  icmp_eval = {1'b0, !s_lt && !eq};
      OP_SGE:  icmp_eval = {1'b0, !s_lt};
      OP_SLT:  icmp_eval = {1'b0, s_lt};
      OP_SLE:  icmp_eval = {1'b0, s_lt || eq};
      default: icmp_eval = 2'b10;
    endcase
  endfunction

  logic [ParamIdWidth-1:0] ptr_q, ptr_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [ParamIdWidth-1:0] rsp_id_q, rsp_id_d;
  logic                    rsp_ret_q, rsp_ret_d;
  logic                    rsp_err_q, rsp_err_d;

  logic                     slot_free;
  logic                     grant_valid;
  logic [ParamIdWidth-1:0]  grant_idx;
  logic                     transfer;
  logic [1:0]               cmp_res;
  int                       idx;

  assign slot_free = !rsp_valid_q || rsp_ready;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < ParamNumReq; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= ParamNumReq) idx = idx - ParamNumReq;
      if (!grant_valid && req_valid[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = ParamIdWidth'(idx);
      end
    end
  end

  assign transfer = grant_valid && slot_free;

  always_comb begin
    req_ready = '0;
    if (transfer) req_ready[grant_idx] = 1'b1;
  end

  assign cmp_res = icmp_eval(req_op[4*int'(grant_idx) +: 4],
                             req_lhs[ParamBitWidth*int'(grant_idx) +: ParamBitWidth],
                             req_rhs[ParamBitWidth*int'(grant_idx) +: ParamBitWidth]);

  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_ret_d   = rsp_ret_q;
    rsp_err_d   = rsp_err_q;
    if (transfer) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_idx;
      rsp_ret_d   = cmp_res[0];
      rsp_err_d   = cmp_res[1];
      // Pointer moves past the winner only on a real transfer, so a stalled winner keeps priority.
      ptr_d       = (int'(grant_idx) == ParamNumReq - 1) ? '0
                                                         : grant_idx + ParamIdWidth'(1);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_ret_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_ret_q   <= rsp_ret_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_ret   = rsp_ret_q;
  assign rsp_err   = rsp_err_q;

endmodule
